// File: rtl/csr_bridge_pkg.sv
// Shared types and constants for the CSR timeout bridge and its watchdog.
package csr_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } csr_bridge_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  function automatic int TIMEOUT_W(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/csr_watchdog_counter.sv
// Per-transaction watchdog: counts enabled cycles from a clear and flags the last allowed cycle.
module csr_watchdog_counter
  import csr_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = TIMEOUT_W(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Holding at LAST keeps an exhausted budget exhausted after CMD->RESP.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge value of its inputs regardless of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/csr_timeout_bridge.sv
// Single-outstanding Avalon-MM CSR bridge with a per-transaction watchdog that
// abandons hung transfers, returns an error word for reads and logs the fault.
module csr_timeout_bridge
  import csr_bridge_pkg::*;
#(
  parameter int                 ADDR_W         = 26,
  parameter int                 DATA_W         = 32,
  parameter int                 TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0]  ERR_DATA       = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic              csr_clk_clk,
  input  logic              csr_clk_reset_reset,
  input  logic [ADDR_W-1:0] s_address,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [DATA_W-1:0] s_writedata,
  output logic              s_waitrequest,
  output logic [DATA_W-1:0] s_readdata,
  output logic              s_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  input  logic              err_clear,
  output logic              err_irq,
  output logic [15:0]       timeout_count,
  output logic [ADDR_W-1:0] last_err_addr
);

  csr_bridge_state_t state_q, state_d;
  logic              is_write_q, is_write_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic [DATA_W-1:0] m_writedata_q, m_writedata_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic [DATA_W-1:0] s_readdata_q, s_readdata_d;
  logic              s_readdatavalid_q, s_readdatavalid_d;
  logic              err_irq_q, err_irq_d;
  logic [15:0]       timeout_count_q, timeout_count_d;
  logic [ADDR_W-1:0] last_err_addr_q, last_err_addr_d;
  logic              timer_expired;
  logic              enter_err;

  csr_watchdog_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (csr_clk_clk),
    .rst    (csr_clk_reset_reset),
    .clear  (state_q == ST_IDLE),
    .enable ((state_q == ST_CMD) || (state_q == ST_RESP)),
    .expired(timer_expired)
  );

  // NOTE: every signal written here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d           = state_q;
    is_write_d        = is_write_q;
    m_address_d       = m_address_q;
    m_writedata_d     = m_writedata_q;
    m_read_d          = m_read_q;
    m_write_d         = m_write_q;
    s_readdata_d      = s_readdata_q;
    s_readdatavalid_d = 1'b0;
    err_irq_d         = err_clear ? 1'b0 : err_irq_q;
    timeout_count_d   = timeout_count_q;
    last_err_addr_d   = last_err_addr_q;
    enter_err         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_write || s_read) begin
          is_write_d    = s_write;
          m_address_d   = s_address;
          m_writedata_d = s_writedata;
          m_write_d     = s_write;
          m_read_d      = ~s_write;
          state_d       = ST_CMD;
        end
      end
      ST_CMD: begin
        // A downstream accept in the last budgeted cycle still counts as completion.
        if (!m_waitrequest) begin
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = is_write_q ? ST_IDLE : ST_RESP;
        end else if (timer_expired) begin
          enter_err = 1'b1;
        end
      end
      ST_RESP: begin
        if (m_readdatavalid) begin
          s_readdata_d      = m_readdata;
          s_readdatavalid_d = 1'b1;
          state_d           = ST_IDLE;
        end else if (timer_expired) begin
          enter_err = 1'b1;
        end
      end
      ST_ERR: begin
        err_irq_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Error side effects are registered on entry so they are visible during ERR.
    if (enter_err) begin
      m_read_d        = 1'b0;
      m_write_d       = 1'b0;
      state_d         = ST_ERR;
      err_irq_d       = 1'b1;
      last_err_addr_d = m_address_q;
      if (timeout_count_q != 16'hFFFF) begin
        timeout_count_d = timeout_count_q + 16'd1;
      end
      if (!is_write_q) begin
        s_readdata_d      = ERR_DATA;
        s_readdatavalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge csr_clk_clk) begin
    if (csr_clk_reset_reset) begin
      state_q           <= ST_IDLE;
      is_write_q        <= 1'b0;
      m_address_q       <= '0;
      m_writedata_q     <= '0;
      m_read_q          <= 1'b0;
      m_write_q         <= 1'b0;
      s_readdata_q      <= '0;
      s_readdatavalid_q <= 1'b0;
      err_irq_q         <= 1'b0;
      timeout_count_q   <= '0;
      last_err_addr_q   <= '0;
    end else begin
      state_q           <= state_d;
      is_write_q        <= is_write_d;
      m_address_q       <= m_address_d;
      m_writedata_q     <= m_writedata_d;
      m_read_q          <= m_read_d;
      m_write_q         <= m_write_d;
      s_readdata_q      <= s_readdata_d;
      s_readdatavalid_q <= s_readdatavalid_d;
      err_irq_q         <= err_irq_d;
      timeout_count_q   <= timeout_count_d;
      last_err_addr_q   <= last_err_addr_d;
    end
  end

  assign s_waitrequest   = csr_clk_reset_reset | (state_q != ST_IDLE);
  assign s_readdata      = s_readdata_q;
  assign s_readdatavalid = s_readdatavalid_q;
  assign m_address       = m_address_q;
  assign m_read          = m_read_q;
  assign m_write         = m_write_q;
  assign m_writedata     = m_writedata_q;
  assign err_irq         = err_irq_q;
  assign timeout_count   = timeout_count_q;
  assign last_err_addr   = last_err_addr_q;

endmodule

// File: tb/tb_csr_timeout_bridge.sv
// Directed bench for csr_timeout_bridge: a per-cycle vector table plus hand-written
// sequences for timeout, late response, last-cycle completion, err_clear and reset.
module tb_csr_timeout_bridge;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int TO     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] s_address;
  logic              s_read, s_write;
  logic [DATA_W-1:0] s_writedata;
  logic              s_waitrequest;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  logic [ADDR_W-1:0] m_address;
  logic              m_read, m_write;
  logic [DATA_W-1:0] m_writedata;
  logic              m_waitrequest;
  logic [DATA_W-1:0] m_readdata;
  logic              m_readdatavalid;
  logic              err_clear;
  logic              err_irq;
  logic [15:0]       timeout_count;
  logic [ADDR_W-1:0] last_err_addr;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  csr_timeout_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .csr_clk_clk        (clk),
    .csr_clk_reset_reset(rst),
    .s_address          (s_address),
    .s_read             (s_read),
    .s_write            (s_write),
    .s_writedata        (s_writedata),
    .s_waitrequest      (s_waitrequest),
    .s_readdata         (s_readdata),
    .s_readdatavalid    (s_readdatavalid),
    .m_address          (m_address),
    .m_read             (m_read),
    .m_write            (m_write),
    .m_writedata        (m_writedata),
    .m_waitrequest      (m_waitrequest),
    .m_readdata         (m_readdata),
    .m_readdatavalid    (m_readdatavalid),
    .err_clear          (err_clear),
    .err_irq            (err_irq),
    .timeout_count      (timeout_count),
    .last_err_addr      (last_err_addr)
  );

  typedef struct {
    logic        rst, rd, wr;
    logic [25:0] addr;
    logic [31:0] wdata;
    logic        mwait;
    logic [31:0] mrdata;
    logic        mrdv, eclr;
    logic        e_swait, e_mrd, e_mwr;
    logic [25:0] e_maddr;
    logic [31:0] e_mwdata;
    logic        e_srdv;
    logic [31:0] e_srdata;
    logic        e_irq;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; s_read = 1'b0; s_write = 1'b0; s_address = '0; s_writedata = '0;
    m_waitrequest = 1'b1; m_readdata = '0; m_readdatavalid = 1'b0; err_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    logic early;
    //            rst rd wr addr     wdata          mw mrdata         mv ec | sw mr mw maddr    mwdata         rdv rdata          irq
    vecs[0]  = '{1, 0, 0, 26'h0,  32'h0,         1, 32'h0,         0, 0,  1, 0, 0, 26'h0,  32'h0,         0, 32'h0,         0};
    vecs[1]  = '{0, 0, 0, 26'h0,  32'h0,         1, 32'h0,         0, 0,  0, 0, 0, 26'h0,  32'h0,         0, 32'h0,         0};
    vecs[2]  = '{0, 0, 1, 26'h40, 32'h0000_1234, 0, 32'h0,         0, 0,  1, 0, 1, 26'h40, 32'h0000_1234, 0, 32'h0,         0};
    vecs[3]  = '{0, 0, 0, 26'h0,  32'h0,         0, 32'h0,         0, 0,  0, 0, 0, 26'h40, 32'h0000_1234, 0, 32'h0,         0};
    vecs[4]  = '{0, 1, 0, 26'h44, 32'h0,         1, 32'h0,         0, 0,  1, 1, 0, 26'h44, 32'h0,         0, 32'h0,         0};
    vecs[5]  = '{0, 0, 0, 26'h0,  32'h0,         1, 32'h0,         0, 0,  1, 1, 0, 26'h44, 32'h0,         0, 32'h0,         0};
    vecs[6]  = '{0, 0, 0, 26'h0,  32'h0,         1, 32'h0,         0, 0,  1, 1, 0, 26'h44, 32'h0,         0, 32'h0,         0};
    vecs[7]  = '{0, 0, 0, 26'h0,  32'h0,         1, 32'h0,         0, 0,  1, 1, 0, 26'h44, 32'h0,         0, 32'h0,         0};
    vecs[8]  = '{0, 0, 0, 26'h0,  32'h0,         0, 32'h0,         0, 0,  1, 0, 0, 26'h44, 32'h0,         0, 32'h0,         0};
    vecs[9]  = '{0, 0, 0, 26'h0,  32'h0,         1, 32'h0,         0, 0,  1, 0, 0, 26'h44, 32'h0,         0, 32'h0,         0};
    vecs[10] = '{0, 0, 0, 26'h0,  32'h0,         1, 32'hCAFE_F00D, 1, 0,  0, 0, 0, 26'h44, 32'h0,         1, 32'hCAFE_F00D, 0};
    vecs[11] = '{0, 0, 0, 26'h0,  32'h0,         1, 32'h0,         0, 0,  0, 0, 0, 26'h44, 32'h0,         0, 32'hCAFE_F00D, 0};
    vecs[12] = '{0, 1, 1, 26'h50, 32'hA5A5_5A5A, 0, 32'h0,         0, 0,  1, 0, 1, 26'h50, 32'hA5A5_5A5A, 0, 32'hCAFE_F00D, 0};
    vecs[13] = '{0, 0, 0, 26'h0,  32'h0,         0, 32'h0,         0, 0,  0, 0, 0, 26'h50, 32'hA5A5_5A5A, 0, 32'hCAFE_F00D, 0};
    vecs[14] = '{0, 0, 0, 26'h0,  32'h0,         1, 32'h1111_1111, 1, 0,  0, 0, 0, 26'h50, 32'hA5A5_5A5A, 0, 32'hCAFE_F00D, 0};

    idle_inputs();
    for (int i = 0; i < 15; i++) begin
      rst = vecs[i].rst; s_read = vecs[i].rd; s_write = vecs[i].wr;
      s_address = vecs[i].addr; s_writedata = vecs[i].wdata;
      m_waitrequest = vecs[i].mwait; m_readdata = vecs[i].mrdata;
      m_readdatavalid = vecs[i].mrdv; err_clear = vecs[i].eclr;
      tick();
      check($sformatf("v%0d_s_waitrequest", i), 64'(s_waitrequest), 64'(vecs[i].e_swait));
      check($sformatf("v%0d_m_read", i), 64'(m_read), 64'(vecs[i].e_mrd));
      check($sformatf("v%0d_m_write", i), 64'(m_write), 64'(vecs[i].e_mwr));
      check($sformatf("v%0d_m_address", i), 64'(m_address), 64'(vecs[i].e_maddr));
      check($sformatf("v%0d_m_writedata", i), 64'(m_writedata), 64'(vecs[i].e_mwdata));
      check($sformatf("v%0d_s_readdatavalid", i), 64'(s_readdatavalid), 64'(vecs[i].e_srdv));
      check($sformatf("v%0d_s_readdata", i), 64'(s_readdata), 64'(vecs[i].e_srdata));
      check($sformatf("v%0d_err_irq", i), 64'(err_irq), 64'(vecs[i].e_irq));
      check($sformatf("v%0d_timeout_count", i), 64'(timeout_count), 64'd0);
    end

    // Read timeout: ERR cycle (and the error response) 17 cycles after acceptance.
    idle_inputs();
    s_read = 1'b1; s_address = 26'h88;
    tick();
    idle_inputs();
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (s_readdatavalid) begin
        seen = k;
        break;
      end
    end
    check("to_rdv_cycle", 64'(seen), 64'(TO));
    check("to_rdata", 64'(s_readdata), 64'h0000_0000_DEAD_BEEF);
    check("to_count", 64'(timeout_count), 64'd1);
    check("to_irq", 64'(err_irq), 64'd1);
    check("to_last_addr", 64'(last_err_addr), 64'h88);
    check("to_m_read_low", 64'(m_read), 64'd0);
    check("to_swait_in_err", 64'(s_waitrequest), 64'd1);
    tick();
    check("to_swait_after", 64'(s_waitrequest), 64'd0);
    check("to_rdv_single", 64'(s_readdatavalid), 64'd0);

    // Late response after the timeout is dropped; the next read is served normally.
    tick(); tick(); tick();
    m_readdatavalid = 1'b1; m_readdata = 32'hBAD0_0BAD;
    tick();
    check("late_rdv_dropped", 64'(s_readdatavalid), 64'd0);
    check("late_rdata_kept", 64'(s_readdata), 64'h0000_0000_DEAD_BEEF);
    idle_inputs();
    s_read = 1'b1; s_address = 26'h90;
    tick();
    check("nr_m_read", 64'(m_read), 64'd1);
    idle_inputs();
    m_waitrequest = 1'b0;
    tick();
    check("nr_cmd_dropped", 64'(m_read), 64'd0);
    m_waitrequest = 1'b1; m_readdatavalid = 1'b1; m_readdata = 32'h1357_9BDF;
    tick();
    check("nr_rdv", 64'(s_readdatavalid), 64'd1);
    check("nr_rdata", 64'(s_readdata), 64'h0000_0000_1357_9BDF);
    check("nr_swait", 64'(s_waitrequest), 64'd0);
    idle_inputs();
    tick();
    check("nr_rdv_single", 64'(s_readdatavalid), 64'd0);

    // Completion in the last budgeted cycle (timer = TO-1) beats the timeout.
    s_read = 1'b1; s_address = 26'hA0;
    tick();
    idle_inputs();
    m_waitrequest = 1'b0;
    tick();
    m_waitrequest = 1'b1;
    early = 1'b0;
    for (int k = 2; k <= TO - 1; k++) begin
      tick();
      if (s_readdatavalid || !s_waitrequest) early = 1'b1;
    end
    check("edge_no_early_end", 64'(early), 64'd0);
    m_readdatavalid = 1'b1; m_readdata = 32'h0F0F_A5A5;
    tick();
    idle_inputs();
    check("edge_rdv", 64'(s_readdatavalid), 64'd1);
    check("edge_rdata", 64'(s_readdata), 64'h0000_0000_0F0F_A5A5);
    check("edge_count", 64'(timeout_count), 64'd1);
    check("edge_swait", 64'(s_waitrequest), 64'd0);

    // err_clear alone clears; err_clear during ERR loses to the set.
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("clr_irq", 64'(err_irq), 64'd0);
    s_write = 1'b1; s_address = 26'hC0; s_writedata = 32'h77;
    tick();
    idle_inputs();
    for (int k = 1; k <= TO - 1; k++) tick();
    tick();
    check("wto_swait_in_err", 64'(s_waitrequest), 64'd1);
    check("wto_m_write_low", 64'(m_write), 64'd0);
    check("wto_no_rdv", 64'(s_readdatavalid), 64'd0);
    check("wto_count", 64'(timeout_count), 64'd2);
    check("wto_last_addr", 64'(last_err_addr), 64'hC0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("set_wins_irq", 64'(err_irq), 64'd1);
    check("wto_swait_after", 64'(s_waitrequest), 64'd0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("clr_irq2", 64'(err_irq), 64'd0);
    check("clr_keeps_count", 64'(timeout_count), 64'd2);

    // Reset mid-RESP: no stale response, counters cleared, next read is normal.
    s_read = 1'b1; s_address = 26'hE0;
    tick();
    idle_inputs();
    m_waitrequest = 1'b0;
    tick();
    m_waitrequest = 1'b1;
    rst = 1'b1;
    tick();
    check("rst_swait", 64'(s_waitrequest), 64'd1);
    check("rst_count", 64'(timeout_count), 64'd0);
    check("rst_last_addr", 64'(last_err_addr), 64'd0);
    check("rst_maddr", 64'(m_address), 64'd0);
    check("rst_rdata", 64'(s_readdata), 64'd0);
    rst = 1'b0;
    m_readdatavalid = 1'b1; m_readdata = 32'h0000_0BAD;
    tick();
    check("rst_stale_dropped", 64'(s_readdatavalid), 64'd0);
    check("rst_idle_swait", 64'(s_waitrequest), 64'd0);
    idle_inputs();
    s_read = 1'b1; s_address = 26'hE4;
    tick();
    check("pr_m_address", 64'(m_address), 64'hE4);
    idle_inputs();
    m_waitrequest = 1'b0;
    tick();
    m_waitrequest = 1'b1; m_readdatavalid = 1'b1; m_readdata = 32'h2468_ACE0;
    tick();
    idle_inputs();
    check("pr_rdv", 64'(s_readdatavalid), 64'd1);
    check("pr_rdata", 64'(s_readdata), 64'h0000_0000_2468_ACE0);
    check("pr_count", 64'(timeout_count), 64'd0);
    tick();
    check("pr_rdv_single", 64'(s_readdatavalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/csr_timeout_bridge.md
# csr_timeout_bridge

Single-outstanding Avalon-MM bridge placed directly upstream of `address_decoder_top`'s 26-bit `slave` port. It registers each host CSR command, forwards it to the decoder, and tracks `waitrequest` and `readdatavalid`. A watchdog stops a hung channel from stalling the host: if a slave never responds, the bridge abandons the transaction, returns an error word, and logs the fault.

## Interface
Parameters:
- `ADDR_W`, 26, address width on both sides
- `DATA_W`, 32, data width
- `TIMEOUT_CYCLES`, 1024, cycles allowed per transaction; must be ≥ 2
- `ERR_DATA`, 32'hDEAD_BEEF, read data returned on timeout

Ports:
- `csr_clk_clk`  in  1  sole clock
- `csr_clk_reset_reset`  in  1  reset, synchronous, active-high
- `s_address`  in  ADDR_W  host address
- `s_read`  in  1  host read request
- `s_write`  in  1  host write request
- `s_writedata`  in  DATA_W  host write data
- `s_waitrequest`  out  1  stalls the host
- `s_readdata`  out  DATA_W  read data to host
- `s_readdatavalid`  out  1  one-cycle read response strobe
- `m_address`  out  ADDR_W  to decoder `slave_address`
- `m_read`  out  1  to decoder `slave_read`
- `m_write`  out  1  to decoder `slave_write`
- `m_writedata`  out  DATA_W  to decoder `slave_writedata`
- `m_waitrequest`  in  1  from decoder
- `m_readdata`  in  DATA_W  from decoder
- `m_readdatavalid`  in  1  from decoder
- `err_clear`  in  1  clears `err_irq`
- `err_irq`  out  1  sticky timeout flag
- `timeout_count`  out  16  saturating count of timeouts
- `last_err_addr`  out  ADDR_W  address of the most recent timeout

## Operation
- FSM states: IDLE, CMD, RESP, ERR.
- `s_waitrequest` = `csr_clk_reset_reset` OR (state ≠ IDLE).
- IDLE, on `s_read` or `s_write`:
  - latch address, data and command type; go to CMD; clear the timer.
  - If read and write are asserted together, the write wins and the read is ignored.
- CMD:
  - `m_read` or `m_write` is held high with stable address and data.
  - On `m_waitrequest`=0, drop the command. A write goes to IDLE; a read goes to RESP.
- RESP:
  - On `m_readdatavalid`, register `m_readdata` into `s_readdata` and pulse `s_readdatavalid` for one cycle; go to IDLE.
- Timer:
  - Counts every cycle spent in CMD and RESP; it is not cleared on the CMD→RESP transition.
  - When timer = TIMEOUT_CYCLES−1 and completion is not seen that cycle, go to ERR. If completion arrives in that same cycle, completion wins.
- ERR (one cycle):
  - `m_read`/`m_write` are already low.
  - For a read, `s_readdata` = ERR_DATA and `s_readdatavalid` pulses.
  - `timeout_count` increments, saturating at 16'hFFFF.
  - `last_err_addr` captures the latched address; `err_irq` is set.
  - Go to IDLE.
- `m_readdatavalid` outside RESP is a late or stale response and is dropped; it is never forwarded.
- `err_clear` clears `err_irq`. If it coincides with an ERR cycle, set wins. The counter and `last_err_addr` are cleared only by reset.
- Reset values: state IDLE, `m_read`/`m_write`/`s_readdatavalid`/`err_irq` = 0, `s_readdata`/`m_address`/`m_writedata`/`last_err_addr`/`timeout_count` = 0, `s_waitrequest` = 1 while reset is asserted.
- Reset mid-transaction abandons the transaction immediately; no response is produced.

## Timing
- Host command accepted at cycle T → `m_read`/`m_write` high at T+1.
- Write accepted downstream at cycle A → IDLE at A+1; next host command can be accepted at A+1.
- `m_readdatavalid` at cycle R → `s_readdatavalid` at R+1, with `s_waitrequest` low at R+1.
- Minimum write turnaround is 2 cycles; minimum read turnaround is 3 cycles.
- Timeout: the ERR cycle is T+1+TIMEOUT_CYCLES; `s_waitrequest` is low one cycle later.
- All outputs are registered except `s_waitrequest`, which is decoded from state and reset.

## Structure
- `csr_bridge_pkg`: state enum `csr_bridge_state_t`, default `ERR_DATA`, and a `TIMEOUT_W` function computing `$clog2(TIMEOUT_CYCLES)`.
- One sub-module, `csr_watchdog_counter`: clear/enable/expire counter parameterised by TIMEOUT_CYCLES.
- Everything else stays flat in `csr_timeout_bridge`.

## Test plan
- Write 0x0000_1234 to 0x0040 with `m_waitrequest` low immediately → `m_write` high exactly 1 cycle with matching address and data; `s_waitrequest` low 2 cycles after acceptance.
- Read 0x0044 with a 3-cycle `m_waitrequest` stall and `readdatavalid` 2 cycles later carrying 0xCAFE_F00D → `s_readdata`=0xCAFE_F00D with a single-cycle `s_readdatavalid`.
- Read with `TIMEOUT_CYCLES`=16 and no response → `s_readdatavalid` with 0xDEAD_BEEF at T+17; `timeout_count`=1; `err_irq`=1; `last_err_addr` = read address.
- Late `m_readdatavalid` 5 cycles after that timeout, then a normal read → only the normal read response reaches the host.
- Completion exactly at timer = TIMEOUT_CYCLES−1 → normal response, `timeout_count` unchanged. Separately, `err_clear` in the same cycle as ERR → `err_irq` stays 1.
- Reset asserted mid-RESP, then a new read → no stale response; the new read completes normally and `timeout_count` reads 0.
